// File: rtl/microc_stack_if.sv
// -----------------------------------------------------------------------------
// microc_stack_if
//
// Bundles the control, fetch and observation signals of the microc_stack
// datapath so that a control unit (or a testbench) connects through one port.
//
// Parameters mirror the datapath: WIDTH (data width), PCW (program counter
// width) and SDEPTH (return-stack depth).
//
// Signals (direction seen from the datapath / slave side):
//   instr     in   16      instruction at address pc (combinational fetch)
//   s_inc     in   1       1: sequential PC, 0: jump to instr[PCW-1:0]
//   s_inm     in   1       register write data: 1 immediate, 0 ALU result
//   we3       in   1       register file write enable
//   wez       in   1       zero-flag write enable
//   Op        in   3       ALU operation
//   push      in   1       call
//   pop       in   1       return
//   dbg_sel   in   4       debug read register index
//   pc        out  PCW     current program counter
//   Opcode    out  6       instr[15:10]
//   z         out  1       registered zero flag
//   sp        out  SPW     return-stack occupancy (0..SDEPTH)
//   stack_err out  1       sticky overflow/underflow/conflict flag
//   dbg_data  out  WIDTH   combinational read of register dbg_sel
//
// Modports: master drives the controls and observes the outputs; slave is
// the datapath.
// -----------------------------------------------------------------------------
interface microc_stack_if #(
  parameter int WIDTH  = 8,
  parameter int PCW    = 10,
  parameter int SDEPTH = 4
);
  localparam int SPW = $clog2(SDEPTH) + 1;

  logic [15:0]      instr;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       Op;
  logic             push;
  logic             pop;
  logic [3:0]       dbg_sel;

  logic [PCW-1:0]   pc;
  logic [5:0]       Opcode;
  logic             z;
  logic [SPW-1:0]   sp;
  logic             stack_err;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output instr, s_inc, s_inm, we3, wez, Op, push, pop, dbg_sel,
    input  pc, Opcode, z, sp, stack_err, dbg_data
  );

  modport slave (
    input  instr, s_inc, s_inm, we3, wez, Op, push, pop, dbg_sel,
    output pc, Opcode, z, sp, stack_err, dbg_data
  );

endinterface

// File: rtl/microc_stack.sv
// -----------------------------------------------------------------------------
// microc_stack
//
// Parametrised microc datapath: program counter, 16 x WIDTH register file
// (R0 hardwired to zero), 8-function ALU, registered zero flag, and a
// hardware return-address stack for call/return.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    microc_stack_if.slave: instruction fetch, control strobes,
//          pc/Opcode/z/sp/stack_err outputs and the debug read port
//
// Parameters:
//   WIDTH  data width of registers and ALU (4..32)
//   PCW    program counter / jump address width (4..10)
//   SDEPTH return-stack depth in entries (power of two, 2..16)
//
// pc, z, sp and stack_err are registered; Opcode and dbg_data are
// combinational.
// -----------------------------------------------------------------------------
module microc_stack #(
  parameter int WIDTH  = 8,
  parameter int PCW    = 10,
  parameter int SDEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  microc_stack_if.slave  bus
);

  localparam int SPW = $clog2(SDEPTH) + 1;
  localparam int IW  = $clog2(SDEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PCW-1:0]   pc_q, pc_d;
  logic             z_q, z_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             stack_err_q, stack_err_d;
  logic [WIDTH-1:0] regs_q  [16];
  logic [WIDTH-1:0] regs_d  [16];
  logic [PCW-1:0]   stack_q [SDEPTH];
  logic [PCW-1:0]   stack_d [SDEPTH];

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [3:0]       ra, rb, rd;
  logic [7:0]       imm8;
  logic [WIDTH-1:0] imm_ext;
  logic [PCW-1:0]   jump_target;

  assign ra          = bus.instr[11:8];
  assign rb          = bus.instr[7:4];
  assign rd          = bus.instr[3:0];
  assign imm8        = bus.instr[11:4];
  assign jump_target = bus.instr[PCW-1:0];

  // Size cast zero-extends for WIDTH > 8 and keeps the low bits for WIDTH < 8.
  assign imm_ext = WIDTH'(imm8);

  // ---------------------------------------------------------------------------
  // Register file reads (R0 always reads zero)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a, op_b;

  assign op_a = (ra == 4'd0) ? '0 : regs_q[ra];
  assign op_b = (rb == 4'd0) ? '0 : regs_q[rb];

  // ---------------------------------------------------------------------------
  // ALU: all arithmetic wraps modulo 2^WIDTH
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_y;

  always_comb begin
    alu_y = '0;
    case (bus.Op)
      3'b000:  alu_y = op_a;
      3'b001:  alu_y = ~op_a;
      3'b010:  alu_y = op_a + op_b;
      3'b011:  alu_y = op_a - op_b;
      3'b100:  alu_y = op_a & op_b;
      3'b101:  alu_y = op_a | op_b;
      3'b110:  alu_y = '0 - op_a;
      3'b111:  alu_y = '0 - op_b;
      default: alu_y = '0;
    endcase
  end

  logic [WIDTH-1:0] wdata;
  assign wdata = bus.s_inm ? imm_ext : alu_y;

  // ---------------------------------------------------------------------------
  // Program counter helpers and stack indices
  // ---------------------------------------------------------------------------
  logic [PCW-1:0] pc_inc;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;

  // PC+1 naturally wraps from 2^PCW-1 to 0 at this width.
  assign pc_inc = pc_q + PCW'(1);

  // push_idx is only used while sp < SDEPTH, so dropping the top bit is safe.
  assign push_idx = IW'(sp_q);
  assign top_idx  = IW'(sp_q - SPW'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // Stack control has priority: conflict, then return, then call, then the
  // normal sequential/jump selection. Register and zero-flag writes are
  // independent of the stack operation in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    z_d         = z_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    regs_d      = regs_q;
    stack_d     = stack_q;

    if (bus.push && bus.pop) begin
      pc_d        = pc_inc;
      stack_err_d = 1'b1;
    end else if (bus.pop) begin
      if (sp_q != '0) begin
        pc_d = stack_q[top_idx];
        sp_d = sp_q - SPW'(1);
      end else begin
        pc_d        = pc_inc;
        stack_err_d = 1'b1;
      end
    end else if (bus.push) begin
      // The call target is taken even on overflow; only the save is dropped.
      pc_d = jump_target;
      if (sp_q < SP_FULL) begin
        stack_d[push_idx] = pc_inc;
        sp_d              = sp_q + SPW'(1);
      end else begin
        stack_err_d = 1'b1;
      end
    end else begin
      pc_d = bus.s_inc ? pc_inc : jump_target;
    end

    if (bus.we3 && (rd != 4'd0)) begin
      regs_d[rd] = wdata;
    end

    // The flag always follows the ALU, even when the immediate is written.
    if (bus.wez) begin
      z_d = (alu_y == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      z_q         <= 1'b0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      for (int j = 0; j < SDEPTH; j++) begin
        stack_q[j] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      z_q         <= z_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      for (int j = 0; j < SDEPTH; j++) begin
        stack_q[j] <= stack_d[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc        = pc_q;
  assign bus.z         = z_q;
  assign bus.sp        = sp_q;
  assign bus.stack_err = stack_err_q;
  assign bus.Opcode    = bus.instr[15:10];
  assign bus.dbg_data  = (bus.dbg_sel == 4'd0) ? '0 : regs_q[bus.dbg_sel];

endmodule
